flex_counter: RTL and testbench
===============================

FLEX_COUNTER -- requirements
Module: flex_counter

Interface
REQ-001 Parameter WIDTH, default 8: counter, load and limit width, legal range 2..32.
REQ-002 Parameter RESET_VALUE, default 0: counter value after reset; must be < 2^WIDTH.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous active-low reset; 0 sampled at a clk rising edge resets the block.
REQ-005 io_enable  in  1  count step request for this cycle.
REQ-006 io_up  in  1  direction; 1 = increment, 0 = decrement.
REQ-007 io_mode  in  2  terminal behaviour: 0 = wrap, 1 = saturate, 2 = one-shot, 3 = reserved, behaves as wrap.
REQ-008 io_limit  in  WIDTH  upper terminal value; counting range is 0..io_limit.
REQ-009 io_load  in  1  load request.
REQ-010 io_loadValue  in  WIDTH  value written on load.
REQ-011 io_clear  in  1  synchronous clear request.
REQ-012 io_cond1  in  1  external flag force.
REQ-013 io_state  out  WIDTH  current counter value, registered.
REQ-014 io_flag  out  1  combinational: (counter == 0) OR io_cond1.
REQ-015 io_tick  out  1  registered one-cycle pulse marking a terminal event.
REQ-016 io_sticky  out  1  registered, set on any terminal event, held until clear or reset.
REQ-017 io_running  out  1  1 when FSM is in RUN, 0 when in HALT.

Function
REQ-018 FSM SHALL have two states, RUN and HALT; only one-shot mode enters HALT.
REQ-019 Per-edge priority SHALL be: reset > io_clear > io_load > enabled count step.
REQ-020 io_clear SHALL set counter = 0, io_sticky = 0 and io_tick = 0, and SHALL move the FSM to RUN.
REQ-021 io_load without io_clear SHALL set counter = io_loadValue and io_tick = 0, SHALL move the FSM to RUN, and SHALL leave io_sticky unchanged; io_loadValue > io_limit is accepted as is.
REQ-022 A count step SHALL occur only when io_enable = 1, the FSM is in RUN, and neither io_clear nor io_load is asserted.
REQ-023 Up terminal condition SHALL be counter >= io_limit; down terminal condition SHALL be counter == 0.
REQ-024 Non-terminal step SHALL be counter ± 1, computed modulo 2^WIDTH.
REQ-025 Terminal up step: wrap mode SHALL go to 0; saturate mode SHALL set counter = io_limit; one-shot mode SHALL set counter = io_limit and enter HALT.
REQ-026 Terminal down step: wrap mode SHALL go to io_limit; saturate mode SHALL hold 0; one-shot mode SHALL hold 0 and enter HALT.
REQ-027 Every terminal step SHALL set io_tick = 1 for exactly the next cycle and SHALL set io_sticky.
REQ-028 io_tick SHALL be 0 in every cycle not following a terminal step; repeated saturate hits SHALL pulse on each enabled cycle.
REQ-029 In HALT, io_enable SHALL be ignored; counter SHALL hold and io_running = 0.
REQ-030 Changes to io_mode, io_limit or io_up SHALL take effect on the next evaluated step, with no internal latching.
REQ-031 io_limit = 0 in wrap mode SHALL hold the counter at 0 and pulse io_tick on every enabled cycle.

Reset
REQ-032 On reset: counter = RESET_VALUE, FSM = RUN, io_tick = 0, io_sticky = 0.
REQ-033 Reset asserted mid-count or in HALT SHALL override all other inputs on that edge, and SHALL be the only recovery besides clear or load.
REQ-034 io_flag SHALL be valid in the first cycle after reset (1 when RESET_VALUE = 0).

Verification
REQ-035 WIDTH=8, wrap, up, limit=3, enable held 6 cycles from 0 -> state 1,2,3,0,1,2; io_tick high only in the cycle after 3->0; io_sticky=1.
REQ-036 Saturate, down, load 2, enable 4 cycles -> state 1,0,0,0; io_tick pulses after each of the last two steps; io_flag=1 from the cycle state reaches 0.
REQ-037 One-shot, up, limit=5, from 4, enable held -> state 5, then HALT with io_running=0 and state frozen; next load 1 -> io_running=1 and counting resumes.
REQ-038 io_clear, io_load and io_enable all asserted with state=7 -> state=0, io_sticky=0; load value ignored.
REQ-039 reset=0 asserted during a one-shot HALT with RESET_VALUE=0 -> next cycle state=0, io_running=1, io_tick=0, io_sticky=0, io_flag=1.
REQ-040 Wrap, up, limit=10, load 200, enable -> next state 0 with io_tick pulse; io_cond1=1 forces io_flag=1 at any count.

Source files
------------

// File: rtl/flex_counter.sv
// Up/down counter with a programmable upper limit and wrap, saturate or one-shot terminal behaviour.
// A one-shot terminal step halts counting until a clear, a load or a reset.
module flex_counter #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_enable,
    input  logic             io_up,
    input  logic [1:0]       io_mode,
    input  logic [WIDTH-1:0] io_limit,
    input  logic             io_load,
    input  logic [WIDTH-1:0] io_loadValue,
    input  logic             io_clear,
    input  logic             io_cond1,
    output logic [WIDTH-1:0] io_state,
    output logic             io_flag,
    output logic             io_tick,
    output logic             io_sticky,
    output logic             io_running
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } run_state_t;

    localparam logic [1:0] MODE_SATURATE = 2'd1;
    localparam logic [1:0] MODE_ONE_SHOT = 2'd2;

    run_state_t       state_q, state_d;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic             tick_q, tick_d;
    logic             sticky_q, sticky_d;
    logic             terminal;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= RUN;
            counter_q <= RESET_VALUE;
            tick_q    <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            tick_q    <= tick_d;
            sticky_q  <= sticky_d;
        end
    end

    // Priority: clear, then load, then an enabled step while running.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        tick_d    = 1'b0;
        sticky_d  = sticky_q;
        terminal  = 1'b0;

        if (io_clear) begin
            counter_d = '0;
            sticky_d  = 1'b0;
            state_d   = RUN;
        end else if (io_load) begin
            counter_d = io_loadValue;
            state_d   = RUN;
        end else if (io_enable && state_q == RUN) begin
            if (io_up) begin
                if (counter_q >= io_limit) begin
                    terminal = 1'b1;
                    case (io_mode)
                        MODE_SATURATE: counter_d = io_limit;
                        MODE_ONE_SHOT: begin
                            counter_d = io_limit;
                            state_d   = HALT;
                        end
                        default:       counter_d = '0;
                    endcase
                end else begin
                    counter_d = counter_q + WIDTH'(1);
                end
            end else begin
                if (counter_q == '0) begin
                    terminal = 1'b1;
                    case (io_mode)
                        MODE_SATURATE: counter_d = '0;
                        MODE_ONE_SHOT: begin
                            counter_d = '0;
                            state_d   = HALT;
                        end
                        default:       counter_d = io_limit;
                    endcase
                end else begin
                    counter_d = counter_q - WIDTH'(1);
                end
            end

            if (terminal) begin
                tick_d   = 1'b1;
                sticky_d = 1'b1;
            end
        end
    end

    assign io_state   = counter_q;
    assign io_flag    = (counter_q == '0) || io_cond1;
    assign io_tick    = tick_q;
    assign io_sticky  = sticky_q;
    assign io_running = (state_q == RUN);

endmodule

// File: tb/tb_flex_counter.sv
// Directed self-checking bench for flex_counter (WIDTH=8, RESET_VALUE=0).
// Expected values are hand-computed for each vector.
module tb_flex_counter;

    logic       clk;
    logic       reset;
    logic       io_enable;
    logic       io_up;
    logic [1:0] io_mode;
    logic [7:0] io_limit;
    logic       io_load;
    logic [7:0] io_loadValue;
    logic       io_clear;
    logic       io_cond1;
    logic [7:0] io_state;
    logic       io_flag;
    logic       io_tick;
    logic       io_sticky;
    logic       io_running;

    int checkCount;
    int failCount;

    flex_counter #(.WIDTH(8), .RESET_VALUE(8'd0)) dut (
        .clk          (clk),
        .reset        (reset),
        .io_enable    (io_enable),
        .io_up        (io_up),
        .io_mode      (io_mode),
        .io_limit     (io_limit),
        .io_load      (io_load),
        .io_loadValue (io_loadValue),
        .io_clear     (io_clear),
        .io_cond1     (io_cond1),
        .io_state     (io_state),
        .io_flag      (io_flag),
        .io_tick      (io_tick),
        .io_sticky    (io_sticky),
        .io_running   (io_running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of control inputs, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic en, input logic ld, input logic [7:0] ldv, input logic clr);
        io_enable    = en;
        io_load      = ld;
        io_loadValue = ldv;
        io_clear     = clr;
        @(posedge clk);
        #1;
        io_enable = 1'b0;
        io_load   = 1'b0;
        io_clear  = 1'b0;
    endtask

    int expState[6];
    int expTick[6];
    int expFlag[4];

    initial begin
        checkCount   = 0;
        failCount    = 0;
        reset        = 1'b0;
        io_enable    = 1'b0;
        io_up        = 1'b1;
        io_mode      = 2'd0;
        io_limit     = 8'd3;
        io_load      = 1'b0;
        io_loadValue = 8'd0;
        io_clear     = 1'b0;
        io_cond1     = 1'b0;

        // Reset state
        @(posedge clk);
        #1;
        reset = 1'b1;
        checkOutput("rst_state", int'(io_state), 0);
        checkOutput("rst_running", int'(io_running), 1);
        checkOutput("rst_tick", int'(io_tick), 0);
        checkOutput("rst_sticky", int'(io_sticky), 0);
        checkOutput("rst_flag", int'(io_flag), 1);

        // Wrap up, limit 3: 1,2,3,0,1,2 with a tick only after 3->0
        expState = '{1, 2, 3, 0, 1, 2};
        expTick  = '{0, 0, 0, 1, 0, 0};
        io_mode = 2'd0; io_up = 1'b1; io_limit = 8'd3;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
            checkOutput($sformatf("wrap_state%0d", i), int'(io_state), expState[i]);
            checkOutput($sformatf("wrap_tick%0d", i), int'(io_tick), expTick[i]);
        end
        checkOutput("wrap_sticky", int'(io_sticky), 1);

        applyStimulus(1'b0, 1'b0, 8'd0, 1'b1);
        checkOutput("clr_state", int'(io_state), 0);
        checkOutput("clr_sticky", int'(io_sticky), 0);

        // Saturate down from 2: 1,0,0,0
        io_mode = 2'd1; io_up = 1'b0;
        applyStimulus(1'b0, 1'b1, 8'd2, 1'b0);
        checkOutput("sat_load", int'(io_state), 2);
        expState[0:3] = '{1, 0, 0, 0};
        expTick[0:3]  = '{0, 0, 1, 1};
        expFlag       = '{0, 1, 1, 1};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
            checkOutput($sformatf("satd_state%0d", i), int'(io_state), expState[i]);
            checkOutput($sformatf("satd_tick%0d", i), int'(io_tick), expTick[i]);
            checkOutput($sformatf("satd_flag%0d", i), int'(io_flag), expFlag[i]);
        end

        // Saturate up at the limit pulses on every enabled cycle
        io_up = 1'b1; io_limit = 8'd3;
        applyStimulus(1'b0, 1'b1, 8'd3, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("satu_state0", int'(io_state), 3);
        checkOutput("satu_tick0", int'(io_tick), 1);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("satu_tick1", int'(io_tick), 1);
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        checkOutput("idle_tick", int'(io_tick), 0);
        checkOutput("idle_state", int'(io_state), 3);

        // One-shot up, limit 5, from 4
        io_mode = 2'd2; io_up = 1'b1; io_limit = 8'd5;
        applyStimulus(1'b0, 1'b1, 8'd4, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("os_state0", int'(io_state), 5);
        checkOutput("os_run0", int'(io_running), 1);
        checkOutput("os_tick0", int'(io_tick), 0);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("os_state1", int'(io_state), 5);
        checkOutput("os_run1", int'(io_running), 0);
        checkOutput("os_tick1", int'(io_tick), 1);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("os_halt_state", int'(io_state), 5);
        checkOutput("os_halt_tick", int'(io_tick), 0);
        checkOutput("os_halt_run", int'(io_running), 0);
        applyStimulus(1'b0, 1'b1, 8'd1, 1'b0);
        checkOutput("os_reload_state", int'(io_state), 1);
        checkOutput("os_reload_run", int'(io_running), 1);
        checkOutput("os_reload_sticky", int'(io_sticky), 1);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("os_resume", int'(io_state), 2);

        // Run into HALT again, then reset overrides load and enable
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("os_halt2_run", int'(io_running), 0);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'd9, 1'b0);
        reset = 1'b1;
        checkOutput("hrst_state", int'(io_state), 0);
        checkOutput("hrst_run", int'(io_running), 1);
        checkOutput("hrst_tick", int'(io_tick), 0);
        checkOutput("hrst_sticky", int'(io_sticky), 0);
        checkOutput("hrst_flag", int'(io_flag), 1);

        // Clear beats load and enable; sticky was set beforehand
        io_mode = 2'd0; io_up = 1'b1; io_limit = 8'd7;
        applyStimulus(1'b0, 1'b1, 8'd7, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("pre_sticky", int'(io_sticky), 1);
        applyStimulus(1'b0, 1'b1, 8'd7, 1'b0);
        checkOutput("load_keeps_sticky", int'(io_sticky), 1);
        checkOutput("load_state", int'(io_state), 7);
        applyStimulus(1'b1, 1'b1, 8'd99, 1'b1);
        checkOutput("prio_state", int'(io_state), 0);
        checkOutput("prio_sticky", int'(io_sticky), 0);
        checkOutput("prio_tick", int'(io_tick), 0);

        // Load above limit then wrap up; cond1 forces the flag
        io_limit = 8'd10;
        applyStimulus(1'b0, 1'b1, 8'd200, 1'b0);
        checkOutput("big_state", int'(io_state), 200);
        checkOutput("big_flag", int'(io_flag), 0);
        io_cond1 = 1'b1;
        #1;
        checkOutput("cond1_flag", int'(io_flag), 1);
        io_cond1 = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("big_wrap_state", int'(io_state), 0);
        checkOutput("big_wrap_tick", int'(io_tick), 1);

        // Limit 0 in wrap holds at 0 and ticks every enabled cycle
        io_limit = 8'd0;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
            checkOutput($sformatf("lim0_state%0d", i), int'(io_state), 0);
            checkOutput($sformatf("lim0_tick%0d", i), int'(io_tick), 1);
        end

        // Wrap down from 0 goes to the limit
        io_up = 1'b0; io_limit = 8'd4;
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("wrapd_state0", int'(io_state), 4);
        checkOutput("wrapd_tick0", int'(io_tick), 1);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("wrapd_state1", int'(io_state), 3);
        checkOutput("wrapd_tick1", int'(io_tick), 0);

        // Reserved mode behaves as wrap
        io_mode = 2'd3; io_up = 1'b1; io_limit = 8'd2;
        applyStimulus(1'b0, 1'b1, 8'd2, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        checkOutput("m3_state", int'(io_state), 0);
        checkOutput("m3_tick", int'(io_tick), 1);
        checkOutput("m3_run", int'(io_running), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
